return_stack: RTL and testbench
===============================

Name: return_stack

Overview:
- 64-deep, 16-bit hardware return stack for the stack processor; holds return addresses for call/return.
- Shift-register organisation: every entry moves one slot on push or pop, so there is no pointer and no full/empty flag.
- Top-of-stack is always visible on output `a`.
- Overflow silently discards the bottom entry; underflow returns zeros.

Parameters:
- WIDTH, 16, data width of each entry and of `w` / `a`.
- DEPTH, 64, number of entries; entry 0 is the top.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears every entry to 0.
- stackOP  input  2  operation select, sampled at rising CLK.
- w  input  WIDTH  data to push or write.
- a  output  WIDTH (signed)  current top-of-stack (entry 0).

Behaviour:
- Storage: DEPTH registers s[0..DEPTH-1]; s[0] = top. `a` is driven combinationally from s[0], with no extra register stage.
- Reset:
  - While reset=1, all s[i] = 0, so a = 0, regardless of CLK or stackOP.
  - Reset is asynchronous and takes priority over any operation in the same cycle.
  - Asserting reset mid-sequence discards all contents.
- stackOP decode at rising CLK when reset=0:
  - 0 = hold: no change.
  - 1 = push: s[0] <= w; s[i] <= s[i-1] for i = 1..DEPTH-1. The old s[DEPTH-1] is lost.
  - 2 = write top: s[0] <= w; s[1..DEPTH-1] unchanged.
  - 3 = pop: s[i] <= s[i+1] for i = 0..DEPTH-2; s[DEPTH-1] <= 0.
- Latency: the new top appears on `a` immediately after the rising edge that performs the op (one cycle from stackOP/w setup).
- Overflow:
  - Push number DEPTH+1 discards the oldest value with no indication.
  - After N > DEPTH pushes, only the last DEPTH values remain.
- Underflow:
  - Popping an empty or partially filled stack shifts in zeros, so `a` reads 0 once all valid data is consumed.
  - No error flag; repeated pops keep a = 0.
- Data is stored unmodified; `a` is simply declared signed for consumers. No arithmetic is performed.
- No simultaneous-operation conflicts: exactly one op per cycle via stackOP.

Test Plan:
- Reset then push 1 -> after one clock a = 1.
- Reset; push 2, push 4; pop -> a = 2; pop -> a = 0 (underflow yields zero).
- Reset; push 1..64 (64 pushes); pop 63 times -> a = 1 (full depth retained).
- Reset; push 1..65; pop 64 times -> a = 0 (value 1 lost on overflow).
- Reset; push 5, push 7; write-top (op 2) with w = 9 -> a = 9; pop -> a = 5.
- Push 3 values, then assert reset asynchronously between clock edges -> a = 0 immediately; a subsequent pop still gives a = 0; hold (op 0) keeps a unchanged over several clocks.

Source files
------------

// File: rtl/return_stack.sv
// ---------------------------------------------------------------------------
// return_stack
//   Shift-register return stack for the stack processor. Each push or pop
//   moves every entry by one slot, so there is no pointer and no full/empty
//   flag. Entry 0 is the top of stack and is always visible on `a`.
//   A push onto a full stack drops the bottom entry without any indication.
//   A pop shifts a zero into the bottom, so an exhausted stack reads 0.
//
// Ports
//   CLK      : system clock, all state updates on the rising edge
//   reset    : asynchronous, active-high; clears every entry to 0
//   stackOP  : 0 = hold, 1 = push, 2 = write top, 3 = pop
//   w        : data for push / write top
//   a        : current top of stack (entry 0), combinational, signed view
// ---------------------------------------------------------------------------
module return_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic [1:0]              stackOP,
  input  logic [WIDTH-1:0]        w,
  output logic signed [WIDTH-1:0] a
);

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_PUSH  = 2'd1,
    OP_WRITE = 2'd2,
    OP_POP   = 2'd3
  } op_e;

  op_e op;
  assign op = op_e'(stackOP);

  logic [WIDTH-1:0] s [DEPTH];

  // NOTE: every entry is reset, so this array is built from flops rather than
  // a RAM macro; a RAM could not be cleared in one asynchronous event.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) s[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every s[i] read its pre-edge
      // neighbour, which is what lets the whole array shift in one cycle.
      case (op)
        OP_PUSH: begin
          s[0] <= w;
          for (int i = 1; i < DEPTH; i++) s[i] <= s[i-1];
        end
        OP_WRITE: begin
          s[0] <= w;
        end
        OP_POP: begin
          for (int i = 0; i < DEPTH - 1; i++) s[i] <= s[i+1];
          s[DEPTH-1] <= '0;
        end
        default: ;  // hold
      endcase
    end
  end

  // Data is stored unmodified; the signed declaration is for consumers only.
  assign a = $signed(s[0]);

endmodule

// File: tb/tb_return_stack.sv
// ---------------------------------------------------------------------------
// tb_return_stack
//   Directed self-checking bench for return_stack: reset behaviour, push,
//   pop, write-top, full-depth retention, overflow loss, underflow zeros,
//   asynchronous mid-cycle reset and hold.
// ---------------------------------------------------------------------------
module tb_return_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 64;

  localparam logic [1:0] HOLD  = 2'd0;
  localparam logic [1:0] PUSH  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] POP   = 2'd3;

  logic                    CLK;
  logic                    reset;
  logic [1:0]              stackOP;
  logic [WIDTH-1:0]        w;
  logic signed [WIDTH-1:0] a;

  int checks   = 0;
  int failures = 0;

  return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK    (CLK),
    .reset  (reset),
    .stackOP(stackOP),
    .w      (w),
    .a      (a)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Apply one op across one rising edge; returns 1 time unit after the edge.
  task automatic do_op(input logic [1:0] op, input logic [WIDTH-1:0] val);
    stackOP = op;
    w       = val;
    @(posedge CLK);
    #1;
    stackOP = HOLD;
  endtask

  // Reset across one rising edge while a push is requested, to show priority.
  task automatic do_reset();
    stackOP = PUSH;
    w       = 16'hFFFF;
    reset   = 1'b1;
    @(posedge CLK);
    #1;
    check("reset_priority", a, 16'h0000);
    reset   = 1'b0;
    stackOP = HOLD;
  endtask

  initial begin
    reset   = 1'b1;
    stackOP = HOLD;
    w       = '0;
    #1;
    check("reset_state", a, 16'h0000);
    do_reset();

    // Single push
    do_op(PUSH, 16'd1);
    check("push1", a, 16'd1);

    // Push / pop / underflow
    do_reset();
    do_op(PUSH, 16'd2);  check("push2", a, 16'd2);
    do_op(PUSH, 16'd4);  check("push4", a, 16'd4);
    do_op(POP,  16'd0);  check("pop_to_2", a, 16'd2);
    do_op(POP,  16'd0);  check("pop_underflow", a, 16'd0);
    do_op(POP,  16'd0);  check("pop_underflow_again", a, 16'd0);

    // Full depth retained: push 1..64, pop down to 1
    do_reset();
    for (int i = 1; i <= DEPTH; i++) do_op(PUSH, WIDTH'(i));
    check("full_top", a, 16'd64);
    for (int k = 1; k < DEPTH; k++) do_op(POP, 16'd0);
    check("full_bottom_kept", a, 16'd1);
    do_op(POP, 16'd0);
    check("full_drained", a, 16'd0);

    // Overflow: push 1..65, value 1 is lost
    do_reset();
    for (int i = 1; i <= DEPTH + 1; i++) do_op(PUSH, WIDTH'(i));
    check("ovf_top", a, 16'd65);
    for (int k = 1; k < DEPTH; k++) do_op(POP, 16'd0);
    check("ovf_oldest_kept_is_2", a, 16'd2);
    do_op(POP, 16'd0);
    check("ovf_value1_lost", a, 16'd0);

    // Write top
    do_reset();
    do_op(PUSH,  16'd5);
    do_op(PUSH,  16'd7);
    do_op(WRITE, 16'd9);  check("write_top", a, 16'd9);
    do_op(POP,   16'd0);  check("write_pop", a, 16'd5);
    do_op(POP,   16'd0);  check("write_no_push", a, 16'd0);

    // Asynchronous reset between edges
    do_op(PUSH, 16'h0011);
    do_op(PUSH, 16'h0022);
    do_op(PUSH, 16'h0033);
    check("pre_async_reset", a, 16'h0033);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_immediate", a, 16'h0000);
    #3;
    reset = 1'b0;
    do_op(POP, 16'd0);
    check("pop_after_reset", a, 16'h0000);

    // Hold keeps a negative (sign bit set) value unchanged
    do_op(PUSH, 16'h8001);
    check("push_signed", a, 16'h8001);
    for (int k = 0; k < 3; k++) begin
      do_op(HOLD, 16'h1234);
      check($sformatf("hold_%0d", k), a, 16'h8001);
    end
    do_op(POP, 16'd0);
    check("pop_after_hold", a, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
